// File: rtl/ex1_4_onehot_seg7.sv
// One-hot to 7-segment decoder: shows index of the single set bit of d, flags zero/multi-hot input.
// Latency: one clock (d sampled at edge k is visible on y/err/zero after edge k).
// Backpressure: none; d is sampled every cycle, outputs hold between edges.
// Optional build macro: SEG7_ACTIVE_LOW_EN inverts y for common-anode displays.
module ex1_4_onehot_seg7 #(
    parameter bit         BLANK_ON_ZERO = 1'b1,
    parameter logic [6:0] ERR_GLYPH     = 7'b1111001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d,
    output logic [6:0] y,
    output logic       err,
    output logic       zero
);

    // Glyph shown for all-zero d: blank, or a single dash on segment g.
    localparam logic [6:0] ZERO_GLYPH = BLANK_ON_ZERO ? 7'b0000000 : 7'b1000000;

`ifdef SEG7_ACTIVE_LOW_EN
    // Common-anode: every pattern, including reset blank, is inverted.
    localparam logic [6:0] SEG_POL = 7'b1111111;
`else
    localparam logic [6:0] SEG_POL = 7'b0000000;
`endif

    logic [3:0] ones;
    logic [2:0] idx;
    logic       is_zero;
    logic       is_multi;
    logic [6:0] digit_glyph;
    logic [6:0] y_nxt;

    // Population count of d; classification needs no priority logic.
    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'b000, d[i]};
        end
    end

    assign is_zero  = (ones == 4'd0);
    assign is_multi = (ones >= 4'd2);

    // Index of the set bit; only meaningful when d is exactly one-hot.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) begin
                idx = 3'(i);
            end
        end
    end

    // Digit glyph table, gfedcba order, active-high.
    always_comb begin
        case (idx)
            3'd0:    digit_glyph = 7'b0111111;
            3'd1:    digit_glyph = 7'b0000110;
            3'd2:    digit_glyph = 7'b1011011;
            3'd3:    digit_glyph = 7'b1001111;
            3'd4:    digit_glyph = 7'b1100110;
            3'd5:    digit_glyph = 7'b1101101;
            3'd6:    digit_glyph = 7'b1111101;
            default: digit_glyph = 7'b0000111;
        endcase
    end

    // Select displayed pattern: multi-hot shows the error glyph, never a partial decode.
    always_comb begin
        y_nxt = digit_glyph;
        if (is_zero) begin
            y_nxt = ZERO_GLYPH;
        end else if (is_multi) begin
            y_nxt = ERR_GLYPH;
        end
    end

    // Register outputs; synchronous active-low reset blanks the digit and clears flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y    <= SEG_POL;
            err  <= 1'b0;
            zero <= 1'b0;
        end else begin
            y    <= y_nxt ^ SEG_POL;
            err  <= is_multi;
            zero <= is_zero;
        end
    end

endmodule

// File: tb/tb_ex1_4_onehot_seg7.sv
// Bench for ex1_4_onehot_seg7: directed vectors with hand-computed expectations,
// queued by the driver and compared by an independent monitor one cycle later.
// A second instance with BLANK_ON_ZERO=0 covers the dash-on-zero variant.
module tb_ex1_4_onehot_seg7;

    typedef struct {
        logic [6:0] y;
        logic       err;
        logic       zero;
        logic [6:0] y_dash;
    } exp_t;

`ifdef SEG7_ACTIVE_LOW_EN
    localparam logic [6:0] POL = 7'b1111111;
`else
    localparam logic [6:0] POL = 7'b0000000;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d = 8'h00;
    logic [6:0] y, y_dash;
    logic       err, zero, err_dash, zero_dash;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    ex1_4_onehot_seg7 u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (d),
        .y    (y),
        .err  (err),
        .zero (zero)
    );

    ex1_4_onehot_seg7 #(.BLANK_ON_ZERO(1'b0)) u_dut_dash (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (d),
        .y    (y_dash),
        .err  (err_dash),
        .zero (zero_dash)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, expv, $time);
        end else begin
            passed++;
        end
    endtask

    // Apply one vector at the falling edge, queue its expected response at the rising edge.
    // ey/edash are the active-high patterns; POL converts them for the active-low build.
    task automatic step(input logic rst, input logic [7:0] dv, input logic [6:0] ey,
                        input logic eerr, input logic ezero, input logic [6:0] edash,
                        input bit glitch);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        d     = dv;
        @(posedge clk);
        e.y      = ey ^ POL;
        e.err    = eerr;
        e.zero   = ezero;
        e.y_dash = edash ^ POL;
        exp_q.push_back(e);
        if (glitch) begin
            // Mid-cycle pulse on d must not disturb the held outputs.
            #2 d = 8'hFF;
            #1 d = dv;
            #1;
            chk("hold_y",   {1'b0, y},   {1'b0, e.y});
            chk("hold_err", {7'b0, err}, {7'b0, e.err});
        end
    endtask

    // Monitor: after every rising edge compare outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("y",         {1'b0, y},      {1'b0, e.y});
                chk("err",       {7'b0, err},    {7'b0, e.err});
                chk("zero",      {7'b0, zero},   {7'b0, e.zero});
                chk("y_dash",    {1'b0, y_dash}, {1'b0, e.y_dash});
                chk("err_dash",  {7'b0, err_dash},  {7'b0, e.err});
                chk("zero_dash", {7'b0, zero_dash}, {7'b0, e.zero});
            end
        end
    end

    initial begin
        int wait_cycles;
        // Reset held for two edges overrides a one-hot d.
        step(1'b0, 8'h01, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0);
        step(1'b0, 8'h01, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0);
        // One-hot walk through all eight digits.
        step(1'b1, 8'h01, 7'b0111111, 1'b0, 1'b0, 7'b0111111, 1'b0);
        step(1'b1, 8'h02, 7'b0000110, 1'b0, 1'b0, 7'b0000110, 1'b0);
        step(1'b1, 8'h04, 7'b1011011, 1'b0, 1'b0, 7'b1011011, 1'b0);
        step(1'b1, 8'h08, 7'b1001111, 1'b0, 1'b0, 7'b1001111, 1'b0);
        step(1'b1, 8'h10, 7'b1100110, 1'b0, 1'b0, 7'b1100110, 1'b0);
        step(1'b1, 8'h20, 7'b1101101, 1'b0, 1'b0, 7'b1101101, 1'b0);
        step(1'b1, 8'h40, 7'b1111101, 1'b0, 1'b0, 7'b1111101, 1'b0);
        step(1'b1, 8'h80, 7'b0000111, 1'b0, 1'b0, 7'b0000111, 1'b0);
        // Shift-out to zero: blank vs dash.
        step(1'b1, 8'h00, 7'b0000000, 1'b0, 1'b1, 7'b1000000, 1'b0);
        // Multi-hot shows E, never the lowest bit.
        step(1'b1, 8'h14, 7'b1111001, 1'b1, 1'b0, 7'b1111001, 1'b0);
        step(1'b1, 8'hFF, 7'b1111001, 1'b1, 1'b0, 7'b1111001, 1'b0);
        step(1'b1, 8'h20, 7'b1101101, 1'b0, 1'b0, 7'b1101101, 1'b0);
        step(1'b1, 8'h03, 7'b1111001, 1'b1, 1'b0, 7'b1111001, 1'b0);
        step(1'b1, 8'h81, 7'b1111001, 1'b1, 1'b0, 7'b1111001, 1'b0);
        // Mid-sequence reset, then resume from zero.
        step(1'b0, 8'hFF, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0);
        step(1'b1, 8'h00, 7'b0000000, 1'b0, 1'b1, 7'b1000000, 1'b0);
        // Glitches between edges leave outputs and next sample unaffected.
        step(1'b1, 8'h08, 7'b1001111, 1'b0, 1'b0, 7'b1001111, 1'b1);
        step(1'b1, 8'h08, 7'b1001111, 1'b0, 1'b0, 7'b1001111, 1'b1);
        step(1'b1, 8'h40, 7'b1111101, 1'b0, 1'b0, 7'b1111101, 1'b0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            chk("drain", 8'(exp_q.size()), 8'd0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
